// File: rtl/bus_defs.sv
// Shared CPU data-bus definitions: bus commands, device
// addresses and the interval-timer register layout.
package bus_defs;

  localparam logic [1:0] MNONE  = 2'b00;
  localparam logic [1:0] MREAD  = 2'b01;
  localparam logic [1:0] MWRITE = 2'b10;

  localparam logic [8:0] LEDADDR    = 9'h100;
  localparam logic [8:0] SWADDR     = 9'h140;
  localparam logic [8:0] TIMER_BASE = 9'h180;

  typedef enum logic [1:0] {
    REG_CTRL   = 2'd0,
    REG_COUNT  = 2'd1,
    REG_RELOAD = 2'd2,
    REG_STATUS = 2'd3
  } tmr_reg_e;

  typedef struct packed {
    logic ie;
    logic auto_rl;
    logic en;
  } tmr_ctrl_t;

  function automatic logic [15:0] ctrl_word(
    input tmr_ctrl_t c
  );
    return {13'd0, c};
  endfunction

endpackage

// File: rtl/io_prescaler.sv
// Timer prescaler: divides clk by PRESCALE while enabled.
// Ports: clk_i, rst_i, clear_i (restart), en_i, tick_o (1-cycle pulse).
module io_prescaler #(
  parameter int unsigned PRESCALE = 50000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int unsigned W = $clog2(PRESCALE);
  localparam logic [W-1:0] LAST = W'(PRESCALE - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign tick_o = en_i && (cnt_q == LAST);

  // Clear has priority; a disabled prescaler parks at 0.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear_i || !en_i) begin
      cnt_d = '0;
    end else if (tick_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/io_timer.sv
// Memory-mapped down-counting interval timer with sticky expiry flag.
// Ports: clk, reset, mem_cmd/mem_addr/write_data in; rd_data, rd_en, irq out.
module io_timer
  import bus_defs::*;
#(
  parameter int unsigned PRESCALE = 50000,
  parameter logic [8:0]  BASE     = TIMER_BASE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  mem_cmd,
  input  logic [8:0]  mem_addr,
  input  logic [15:0] write_data,
  output logic [15:0] rd_data,
  output logic        rd_en,
  output logic        irq
);

  logic [8:0] off;
  logic       in_win;
  tmr_reg_e   sel;
  logic       wr;
  logic       wr_ctrl;
  logic       wr_count;
  logic       wr_reload;
  logic       wr_status;

  tmr_ctrl_t   ctrl_q;
  tmr_ctrl_t   ctrl_d;
  logic [15:0] count_q;
  logic [15:0] count_d;
  logic [15:0] reload_q;
  logic [15:0] reload_d;
  logic        exp_q;
  logic        exp_d;

  logic tick;
  logic expire;

  // Window match via offset: the upper bits must be zero.
  assign off    = mem_addr - BASE;
  assign in_win = (off[8:2] == 7'd0);
  assign sel    = tmr_reg_e'(off[1:0]);

  assign wr    = (mem_cmd == MWRITE) && in_win;
  assign rd_en = (mem_cmd == MREAD) && in_win;

  assign wr_ctrl   = wr && (sel == REG_CTRL);
  assign wr_count  = wr && (sel == REG_COUNT);
  assign wr_reload = wr && (sel == REG_RELOAD);
  assign wr_status = wr && (sel == REG_STATUS);

  io_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_presc (
    .clk_i   (clk),
    .rst_i   (reset),
    .clear_i (wr_ctrl),
    .en_i    (ctrl_q.en),
    .tick_o  (tick)
  );

  // COUNT of 0 or 1 both expire, so COUNT never wraps.
  assign expire = tick && (count_q <= 16'd1);

  always_comb begin
    count_d  = count_q;
    ctrl_d   = ctrl_q;
    reload_d = reload_q;
    exp_d    = exp_q;

    if (wr_count) begin
      count_d = write_data;
    end else if (tick) begin
      if (count_q > 16'd1) begin
        count_d = count_q - 16'd1;
      end else if (ctrl_q.auto_rl) begin
        count_d = reload_q;
      end else begin
        count_d = 16'd0;
      end
    end

    if (wr_ctrl) begin
      ctrl_d = tmr_ctrl_t'(write_data[2:0]);
    end else if (expire && !ctrl_q.auto_rl) begin
      ctrl_d.en = 1'b0;
    end

    if (wr_reload) begin
      reload_d = write_data;
    end

    // Setting beats clearing when both land together.
    if (expire) begin
      exp_d = 1'b1;
    end else if (wr_status && write_data[0]) begin
      exp_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q   <= '0;
      count_q  <= '0;
      reload_q <= '0;
      exp_q    <= 1'b0;
    end else begin
      ctrl_q   <= ctrl_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      exp_q    <= exp_d;
    end
  end

  always_comb begin
    rd_data = 16'h0000;
    if (rd_en) begin
      unique case (sel)
        REG_CTRL:   rd_data = ctrl_word(ctrl_q);
        REG_COUNT:  rd_data = count_q;
        REG_RELOAD: rd_data = reload_q;
        REG_STATUS: rd_data = {15'd0, exp_q};
      endcase
    end
  end

  assign irq = exp_q & ctrl_q.ie;

endmodule

// File: tb/tb_io_timer.sv
// Self-checking bench for io_timer with a cycle-level
// behavioural model and random bus traffic.
module tb_io_timer;
  import bus_defs::*;

  localparam int P = 4;
  localparam logic [8:0] B = 9'h180;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  mem_cmd = MNONE;
  logic [8:0]  mem_addr = '0;
  logic [15:0] write_data = '0;
  logic [15:0] rd_data;
  logic        rd_en;
  logic        irq;

  io_timer #(
    .PRESCALE (P),
    .BASE     (B)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_cmd    (mem_cmd),
    .mem_addr   (mem_addr),
    .write_data (write_data),
    .rd_data    (rd_data),
    .rd_en      (rd_en),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  int m_en, m_auto, m_ie;
  int m_count, m_reload, m_exp, m_ph;

  logic [15:0] last_rd;
  logic        last_en;
  logic        last_irq;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  function automatic bit in_win(input logic [8:0] a);
    return (int'(a) >= int'(B)) && (int'(a) <= int'(B) + 3);
  endfunction

  function automatic int m_read(input logic [8:0] a);
    int o;
    o = int'(a) - int'(B);
    case (o)
      0: return m_en | (m_auto << 1) | (m_ie << 2);
      1: return m_count;
      2: return m_reload;
      3: return m_exp;
      default: return 0;
    endcase
  endfunction

  function automatic bit tick_pend();
    return (m_en != 0) && (m_ph == P - 1);
  endfunction

  task automatic model_reset();
    m_en = 0; m_auto = 0; m_ie = 0;
    m_count = 0; m_reload = 0; m_exp = 0; m_ph = 0;
  endtask

  // One clock of the timer described by its rules:
  // ticks fall every P enabled cycles after a CTRL write.
  task automatic model_step(input logic [1:0] c,
                            input logic [8:0] a,
                            input logic [15:0] d);
    bit wr, tk, ex;
    int o, n_cnt, n_en, n_auto, n_ie, n_rl, n_exp, n_ph;
    wr = (c == MWRITE) && in_win(a);
    o = int'(a) - int'(B);
    tk = tick_pend();
    ex = tk && (m_count <= 1);
    n_cnt = m_count;
    if (wr && o == 1) n_cnt = d;
    else if (tk) n_cnt = (m_count > 1) ? m_count - 1
                         : (m_auto != 0 ? m_reload : 0);
    n_en = m_en; n_auto = m_auto; n_ie = m_ie;
    if (wr && o == 0) begin
      n_en = d[0]; n_auto = d[1]; n_ie = d[2];
    end else if (ex && m_auto == 0) n_en = 0;
    n_rl = (wr && o == 2) ? int'(d) : m_reload;
    n_exp = m_exp;
    if (ex) n_exp = 1;
    else if (wr && o == 3 && d[0]) n_exp = 0;
    if ((wr && o == 0) || m_en == 0) n_ph = 0;
    else n_ph = (m_ph + 1) % P;
    m_count = n_cnt; m_en = n_en; m_auto = n_auto;
    m_ie = n_ie; m_reload = n_rl; m_exp = n_exp; m_ph = n_ph;
  endtask

  // Drive one bus cycle from a negedge, check, advance model.
  task automatic cyc(input logic [1:0] c,
                     input logic [8:0] a,
                     input logic [15:0] d);
    mem_cmd = c;
    mem_addr = a;
    write_data = d;
    #1;
    last_rd = rd_data;
    last_en = rd_en;
    last_irq = irq;
    if (c == MREAD) begin
      chk("rd_en", rd_en, in_win(a));
      chk("rd_data", rd_data, in_win(a) ? m_read(a) : 0);
    end else begin
      chk("rd_en_idle", rd_en, 0);
      chk("rd_data_idle", rd_data, 0);
    end
    chk("irq", irq, m_exp & m_ie);
    if (reset) model_reset();
    else model_step(c, a, d);
    @(negedge clk);
  endtask

  task automatic wr(input int o, input logic [15:0] d);
    cyc(MWRITE, B + 9'(o), d);
  endtask

  task automatic rd(input int o);
    cyc(MREAD, B + 9'(o), 16'h0);
  endtask

  task automatic wait_tick(input string tag);
    for (int i = 0; i < 2 * P && !tick_pend(); i++) rd(3);
    chk(tag, tick_pend(), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  c;
    logic [8:0]  a;
    logic [15:0] d;
    model_reset();
    @(negedge clk);
    for (int o = 0; o < 4; o++) begin
      rd(o);
      chk($sformatf("rst_reg%0d", o), last_rd, 0);
    end
    reset = 1'b0;

    wr(2, 16'h1234);
    rd(2);
    chk("reload_rb", last_rd, 16'h1234);
    chk("reload_rden", last_en, 1);
    cyc(MREAD, 9'h140, 16'h0);
    chk("sw_rden", last_en, 0);

    wr(1, 16'd3);
    wr(0, 16'h0005);
    repeat (12) rd(3);
    chk("os_pre", last_rd, 0);
    rd(3);
    chk("os_exp", last_rd, 1);
    chk("os_irq", last_irq, 1);
    rd(1);
    chk("os_count", last_rd, 0);
    rd(0);
    chk("os_ctrl", last_rd, 16'h0004);
    repeat (8) rd(1);
    chk("os_hold", last_rd, 0);

    wr(3, 16'h1);
    wr(2, 16'd2);
    wr(1, 16'd2);
    wr(0, 16'h0003);
    repeat (8) rd(3);
    chk("ar_pre", last_rd, 0);
    rd(3);
    chk("ar_exp", last_rd, 1);
    rd(1);
    chk("ar_count", last_rd, 2);
    wr(3, 16'h1);
    rd(3);
    chk("ar_clr", last_rd, 0);

    wait_tick("col_cnt_wait");
    wr(1, 16'h0010);
    rd(1);
    chk("col_count", last_rd, 16'h0010);

    wr(0, 16'h0);
    wr(3, 16'h1);
    wr(1, 16'd1);
    wr(0, 16'h0001);
    wait_tick("col_st_wait");
    wr(3, 16'h1);
    rd(3);
    chk("col_status", last_rd, 1);

    wr(3, 16'h1);
    wr(1, 16'd0);
    wr(0, 16'h0001);
    repeat (4) rd(3);
    chk("zero_pre", last_rd, 0);
    rd(3);
    chk("zero_exp", last_rd, 1);

    wr(1, 16'hFFFF);
    wr(0, 16'h0001);
    repeat (4) rd(1);
    chk("ff_pre", last_rd, 16'hFFFF);
    rd(1);
    chk("ff_tick", last_rd, 16'hFFFE);

    wr(0, 16'h0005);
    rd(0);
    chk("pre_rst_irq", last_irq, 1);
    #2 reset = 1'b1;
    #1 chk("rst_irq", irq, 0);
    model_reset();
    @(negedge clk);
    for (int o = 0; o < 4; o++) begin
      rd(o);
      chk($sformatf("mid_rst_reg%0d", o), last_rd, 0);
    end
    reset = 1'b0;

    repeat (400) begin
      case ($urandom_range(9))
        0, 1:    c = MNONE;
        2, 3, 4: c = MWRITE;
        default: c = MREAD;
      endcase
      if ($urandom_range(9) < 8) a = B + 9'($urandom_range(3));
      else a = 9'($urandom);
      d = ($urandom_range(3) == 0) ? 16'($urandom)
                                   : 16'($urandom_range(5));
      if (c == MWRITE && a == B && $urandom_range(3) != 0)
        c = MREAD;
      cyc(c, a, d);
    end

    mem_cmd = MNONE;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
